bcd_convert_ctrl: RTL and testbench
===================================

BCD_CONVERT_CTRL -- requirements
Module: bcd_convert_ctrl

Interface
REQ-001 Parameter: OVF_SAT, default 0, meaning 1 = out-of-range result saturates to 8'h99999999 digits, 0 = result is value mod 10^8.
REQ-002 The block SHALL use one clock, and reset SHALL be synchronous and active-low.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 req0_valid  input  1  requester 0 has a binary value pending.
REQ-006 req0_data  input  32  requester 0 unsigned binary value.
REQ-007 req0_ready  output  1  requester 0 value accepted this cycle.
REQ-008 req1_valid  input  1  requester 1 has a binary value pending.
REQ-009 req1_data  input  32  requester 1 unsigned binary value.
REQ-010 req1_ready  output  1  requester 1 value accepted this cycle.
REQ-011 out_valid  output  1  result held on out_* is valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_bcd  output  32  8 packed BCD digits, [3:0] = ones ... [31:28] = 10^7.
REQ-014 out_ovf  output  1  source value was >= 100,000,000.
REQ-015 out_src  output  1  requester index (0/1) that produced the result.

Function
REQ-016 The FSM SHALL have states IDLE, SHIFT, and DONE.
REQ-017 In IDLE, reqN_ready SHALL be asserted combinationally only for the granted requester, and only when that requester's valid is high.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant the requester not served last; with one valid, grant it.
REQ-019 A transfer SHALL occur on a clock edge where reqN_valid & reqN_ready; at that edge the data is captured, the source index is recorded, the 40-bit BCD accumulator is cleared, the iteration counter is set to 0, and the FSM enters SHIFT.
REQ-020 SHIFT SHALL perform one double-dabble iteration per cycle: add 3 to every accumulator digit >= 5, then shift {accumulator, data} left by 1.
REQ-021 SHIFT SHALL run exactly 32 iterations; after the 32nd edge, the FSM SHALL enter DONE.
REQ-022 Latency SHALL be: out_valid high exactly 32 cycles after the accept edge.
REQ-023 In DONE, out_valid SHALL be 1, and out_bcd/out_ovf/out_src SHALL be stable until the out_valid & out_ready edge, which returns the FSM to IDLE.
REQ-024 out_ovf SHALL be 1 iff accumulator digits 9..8 are nonzero.
REQ-025 When OVF_SAT=0, out_bcd SHALL be accumulator[31:0]; when OVF_SAT=1 and out_ovf=1, out_bcd SHALL be 32'h99999999.
REQ-026 Both reqN_ready SHALL be 0 in SHIFT and DONE; minimum spacing between accepts SHALL be 34 cycles.
REQ-027 Requester valid dropping without handshake SHALL be ignored (no capture); data changes while not accepted have no effect.
REQ-028 Inputs arriving during SHIFT/DONE SHALL wait; arbitration SHALL be evaluated again in IDLE.

Reset
REQ-029 On a clk edge with rst_n=0, the block SHALL set state=IDLE, out_valid=0, out_bcd=0, out_ovf=0, out_src=0, iteration counter=0, and set the round-robin pointer so that req0 wins the first contention.
REQ-030 Reset during SHIFT or DONE SHALL abandon the conversion, produce no result, and perform no handshake.
REQ-031 Both reqN_ready SHALL be 0 while rst_n=0.

Structure
REQ-032 Package bcd_pkg SHALL hold the state enum, NDIG=8, ACC_DIG=10, and ITER=32.
REQ-033 One sub-module, bcd_add3_stage, SHALL be used: a combinational per-digit >=5 add-3 correction across ACC_DIG digits, instanced once.
REQ-034 Arbitration, FSM, counter, and output registers SHALL live in bcd_convert_ctrl.

Verification
REQ-035 Scenario: req0 sends 12345678 -> out_bcd=32'h12345678, out_ovf=0, out_src=0, out_valid rises 32 cycles after accept.
REQ-036 Scenario: req1 sends 0 -> out_bcd=32'h00000000, out_ovf=0, out_src=1; 4294967295 -> 32'h94967295, out_ovf=1 (OVF_SAT=0), or 32'h99999999 (OVF_SAT=1).
REQ-037 Scenario: both valid from reset with 11 and 22 -> results 32'h00000011 (src 0), then 32'h00000022 (src 1); repeat with 33 and 44 and confirm req1 wins after a req0-served round.
REQ-038 Scenario: out_ready held low for 10 cycles in DONE -> outputs stable, no readies; FSM returns to IDLE on the edge after out_ready rises.
REQ-039 Scenario: rst_n low for 1 cycle at iteration 15 -> out_valid never asserts for that value; the next request after reset converts correctly, and req0 wins contention.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and sizing for the binary-to-BCD conversion controller.
package bcd_pkg;
    localparam int NDIG    = 8;
    localparam int ACC_DIG = 10;
    localparam int ITER    = 32;
    localparam int ACC_W   = ACC_DIG * 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/bcd_add3_stage.sv
// Combinational double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
module bcd_add3_stage
    import bcd_pkg::*;
(
    input  logic [ACC_W-1:0] i_acc,
    output logic [ACC_W-1:0] o_acc
);

    for (genvar g = 0; g < ACC_DIG; g++) begin : g_dig
        logic [3:0] w_dig;
        assign w_dig = i_acc[g*4 +: 4];
        assign o_acc[g*4 +: 4] = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
    end

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Two-requester round-robin front end feeding a 32-iteration double-dabble converter.
//   state | meaning
//   IDLE  | arbitrate and accept one binary value
//   SHIFT | one add-3/shift iteration per cycle, 32 in total
//   DONE  | result held on out_* until the consumer takes it
module bcd_convert_ctrl
    import bcd_pkg::*;
#(
    parameter bit OVF_SAT = 1'b0
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_bcd,
    output logic        out_ovf,
    output logic        out_src
);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [31:0]        r_data;
    logic [5:0]         r_iter;
    logic               r_src;
    logic               r_last;

    logic               w_idle;
    logic               w_grant1;
    logic [ACC_W-1:0]   w_corr;
    logic [ACC_W-1:0]   w_next_acc;
    logic               w_next_ovf;
    logic               w_last_iter;

    // r_last = 1 means requester 1 was served last, so requester 0 wins a tie.
    assign w_idle     = (r_state == IDLE) && rst_n;
    assign w_grant1   = req1_valid && (!req0_valid || !r_last);
    assign req0_ready = w_idle && req0_valid && !w_grant1;
    assign req1_ready = w_idle && w_grant1;

    bcd_add3_stage u_add3 (
        .i_acc (r_acc),
        .o_acc (w_corr)
    );

    assign w_next_acc  = {w_corr[ACC_W-2:0], r_data[31]};
    assign w_next_ovf  = |w_next_acc[ACC_W-1:NDIG*4];
    assign w_last_iter = (r_iter == 6'(ITER - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_data    <= '0;
            r_iter    <= '0;
            r_src     <= 1'b0;
            r_last    <= 1'b1;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_ovf   <= 1'b0;
            out_src   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        r_data  <= req1_ready ? req1_data : req0_data;
                        r_src   <= req1_ready;
                        r_last  <= req1_ready;
                        r_acc   <= '0;
                        r_iter  <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_acc  <= w_next_acc;
                    r_data <= {r_data[30:0], 1'b0};
                    r_iter <= r_iter + 6'd1;
                    // Outputs are taken from the final iteration's value so they are registered on DONE entry.
                    if (w_last_iter) begin
                        r_state   <= DONE;
                        out_valid <= 1'b1;
                        out_ovf   <= w_next_ovf;
                        out_bcd   <= (OVF_SAT && w_next_ovf) ? 32'h9999_9999 : w_next_acc[31:0];
                        out_src   <= r_src;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Directed bench for bcd_convert_ctrl; a saturating instance shares the stimulus.
module tb_bcd_convert_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, out_ready;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready, out_valid, out_ovf, out_src;
    logic [31:0] out_bcd;
    logic        req0_ready_s, req1_ready_s, out_valid_s, out_ovf_s, out_src_s;
    logic [31:0] out_bcd_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_convert_ctrl #(.OVF_SAT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .out_ovf(out_ovf), .out_src(out_src)
    );

    bcd_convert_ctrl #(.OVF_SAT(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready_s),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready_s),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_bcd(out_bcd_s), .out_ovf(out_ovf_s), .out_src(out_src_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for either ready, then clocks the accept edge.
    task automatic accept_one(output bit got0, output bit got1, output bit ok);
        bit done;
        got0 = 1'b0;
        got1 = 1'b0;
        ok   = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                got0 = req0_ready;
                got1 = req1_ready;
                tick();
                ok   = 1'b1;
                done = 1'b1;
            end else begin
                tick();
            end
        end
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 32'd1;
        req1_valid = 1'b1; req1_data = 32'd2;
        tick(); tick(); #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got r0=%b r1=%b want 0 0", req0_ready, req1_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_bcd !== 32'h0 || out_ovf !== 1'b0 || out_src !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b bcd=%h ovf=%b src=%b want 0 0 0 0",
                     out_valid, out_bcd, out_ovf, out_src);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_req0_basic();
        bit g0, g1, ok;
        int cyc;
        req0_data = 32'd12345678; req0_valid = 1'b1;
        accept_one(g0, g1, ok);
        req0_valid = 1'b0;
        checks++;
        if (!(ok && g0 && !g1)) begin
            failures++;
            $display("FAIL basic_grant got ok=%b g0=%b g1=%b want 1 1 0", ok, g0, g1);
        end
        wait_out(cyc);
        checks++;
        if (cyc != 32) begin
            failures++;
            $display("FAIL basic_latency got %0d want 32", cyc);
        end
        checks++;
        if (out_bcd !== 32'h12345678 || out_ovf !== 1'b0 || out_src !== 1'b0) begin
            failures++;
            $display("FAIL basic_result got bcd=%h ovf=%b src=%b want 12345678 0 0", out_bcd, out_ovf, out_src);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_release got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_req1_values();
        logic [31:0] vin  [2] = '{32'd0, 32'hFFFF_FFFF};
        logic [31:0] vbcd [2] = '{32'h0000_0000, 32'h9496_7295};
        logic [31:0] vsat [2] = '{32'h0000_0000, 32'h9999_9999};
        logic        vovf [2] = '{1'b0, 1'b1};
        bit g0, g1, ok;
        int cyc;
        for (int k = 0; k < 2; k++) begin
            req1_data = vin[k]; req1_valid = 1'b1;
            accept_one(g0, g1, ok);
            req1_valid = 1'b0;
            checks++;
            if (!(ok && g1 && !g0)) begin
                failures++;
                $display("FAIL req1_grant[%0d] got ok=%b g0=%b g1=%b want 1 0 1", k, ok, g0, g1);
            end
            wait_out(cyc);
            checks++;
            if (cyc != 32) begin
                failures++;
                $display("FAIL req1_latency[%0d] got %0d want 32", k, cyc);
            end
            checks++;
            if (out_bcd !== vbcd[k] || out_ovf !== vovf[k] || out_src !== 1'b1) begin
                failures++;
                $display("FAIL req1_result[%0d] got bcd=%h ovf=%b src=%b want %h %b 1",
                         k, out_bcd, out_ovf, out_src, vbcd[k], vovf[k]);
            end
            checks++;
            if (out_valid_s !== 1'b1 || out_bcd_s !== vsat[k] || out_ovf_s !== vovf[k] || out_src_s !== 1'b1) begin
                failures++;
                $display("FAIL sat_result[%0d] got v=%b bcd=%h ovf=%b src=%b want 1 %h %b 1",
                         k, out_valid_s, out_bcd_s, out_ovf_s, out_src_s, vsat[k], vovf[k]);
            end
            consume();
        end
    endtask

    task automatic test_contention();
        bit g0, g1, ok;
        int cyc;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        req0_data = 32'd11; req1_data = 32'd22;
        req0_valid = 1'b1; req1_valid = 1'b1;
        accept_one(g0, g1, ok);
        req0_valid = 1'b0;
        checks++;
        if (!(ok && g0 && !g1)) begin
            failures++;
            $display("FAIL rr_first got ok=%b g0=%b g1=%b want 1 1 0", ok, g0, g1);
        end
        wait_out(cyc);
        checks++;
        if (cyc != 32 || out_bcd !== 32'h11 || out_src !== 1'b0) begin
            failures++;
            $display("FAIL rr_11 got cyc=%0d bcd=%h src=%b want 32 00000011 0", cyc, out_bcd, out_src);
        end
        consume();
        accept_one(g0, g1, ok);
        req1_valid = 1'b0;
        checks++;
        if (!(ok && g1 && !g0)) begin
            failures++;
            $display("FAIL rr_second got ok=%b g0=%b g1=%b want 1 0 1", ok, g0, g1);
        end
        wait_out(cyc);
        checks++;
        if (cyc != 32 || out_bcd !== 32'h22 || out_src !== 1'b1) begin
            failures++;
            $display("FAIL rr_22 got cyc=%0d bcd=%h src=%b want 32 00000022 1", cyc, out_bcd, out_src);
        end
        consume();

        req0_data = 32'd33; req1_data = 32'd44;
        req0_valid = 1'b1; req1_valid = 1'b1;
        accept_one(g0, g1, ok);
        req0_data = 32'd55;
        checks++;
        if (!(ok && g0 && !g1)) begin
            failures++;
            $display("FAIL rr_third got ok=%b g0=%b g1=%b want 1 1 0", ok, g0, g1);
        end
        wait_out(cyc);
        checks++;
        if (cyc != 32 || out_bcd !== 32'h33 || out_src !== 1'b0) begin
            failures++;
            $display("FAIL rr_33 got cyc=%0d bcd=%h src=%b want 32 00000033 0", cyc, out_bcd, out_src);
        end
        consume();
        accept_one(g0, g1, ok);
        req1_valid = 1'b0;
        checks++;
        if (!(ok && g1 && !g0)) begin
            failures++;
            $display("FAIL rr_after_req0 got ok=%b g0=%b g1=%b want 1 0 1", ok, g0, g1);
        end
        wait_out(cyc);
        checks++;
        if (cyc != 32 || out_bcd !== 32'h44 || out_src !== 1'b1) begin
            failures++;
            $display("FAIL rr_44 got cyc=%0d bcd=%h src=%b want 32 00000044 1", cyc, out_bcd, out_src);
        end
        consume();
        accept_one(g0, g1, ok);
        req0_valid = 1'b0;
        wait_out(cyc);
        checks++;
        if (!(ok && g0) || cyc != 32 || out_bcd !== 32'h55 || out_src !== 1'b0) begin
            failures++;
            $display("FAIL rr_55 got ok=%b g0=%b cyc=%0d bcd=%h src=%b want 1 1 32 00000055 0",
                     ok, g0, cyc, out_bcd, out_src);
        end
        consume();
    endtask

    task automatic test_out_stall();
        bit g0, g1, ok;
        int cyc;
        int seen;
        req0_data = 32'd4321; req0_valid = 1'b1;
        accept_one(g0, g1, ok);
        req0_valid = 1'b0;
        wait_out(cyc);
        checks++;
        if (!(ok && g0) || cyc != 32) begin
            failures++;
            $display("FAIL stall_setup got ok=%b g0=%b cyc=%0d want 1 1 32", ok, g0, cyc);
        end
        req1_data = 32'd999; req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_bcd !== 32'h4321 || out_src !== 1'b0 || out_ovf !== 1'b0 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d] got v=%b bcd=%h src=%b ovf=%b r0=%b r1=%b want 1 00004321 0 0 0 0",
                         i, out_valid, out_bcd, out_src, out_ovf, req0_ready, req1_ready);
            end
        end
        req1_valid = 1'b0;
        consume();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_release got out_valid=%b want 0", out_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL dropped_valid_ignored got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        bit g0, g1, ok;
        int cyc;
        req0_data = 32'd77; req0_valid = 1'b1;
        accept_one(g0, g1, ok);
        req0_valid = 1'b0;
        repeat (15) tick();
        rst_n = 1'b0;
        req0_data = 32'd88; req1_data = 32'd99;
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick();
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_quiet got r0=%b r1=%b v=%b want 0 0 0", req0_ready, req1_ready, out_valid);
        end
        rst_n = 1'b1;
        accept_one(g0, g1, ok);
        req0_valid = 1'b0;
        checks++;
        if (!(ok && g0 && !g1)) begin
            failures++;
            $display("FAIL midreset_grant got ok=%b g0=%b g1=%b want 1 1 0", ok, g0, g1);
        end
        wait_out(cyc);
        checks++;
        if (cyc != 32 || out_bcd !== 32'h88 || out_src !== 1'b0) begin
            failures++;
            $display("FAIL midreset_88 got cyc=%0d bcd=%h src=%b want 32 00000088 0", cyc, out_bcd, out_src);
        end
        consume();
        accept_one(g0, g1, ok);
        req1_valid = 1'b0;
        wait_out(cyc);
        checks++;
        if (!(ok && g1) || cyc != 32 || out_bcd !== 32'h99 || out_src !== 1'b1) begin
            failures++;
            $display("FAIL midreset_99 got ok=%b g1=%b cyc=%0d bcd=%h src=%b want 1 1 32 00000099 1",
                     ok, g1, cyc, out_bcd, out_src);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_req0_basic();
        test_req1_values();
        test_contention();
        test_out_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
